muldiv_sequencer: RTL and testbench

Sequences the shared multiply and divide units of the multicycle CPU and owns the HI/LO write path. The main control FSM issues one MULT/DIV request. This block then:
- launches the selected unit;
- waits for its completion flag, with a cycle-budget watchdog;
- steers the HI/LO input muxes and pulses the HI/LO write enables;
- reports divide-by-zero or timeout as an exception pulse, so control can enter its exception states.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_timer.sv | 33 +++
 rtl/muldiv_sequencer.sv | 134 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the MULT/DIV sequencer and its wait timer.
package muldiv_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_MULT = 3'd2,
    S_WAIT_DIV  = 3'd3,
    S_COMMIT    = 3'd4,
    S_EXC       = 3'd5
  } state_e;

  localparam logic KIND_MULT     = 1'b0;
  localparam logic KIND_DIV      = 1'b1;

  localparam logic CAUSE_DIV0    = 1'b0;
  localparam logic CAUSE_TIMEOUT = 1'b1;

endpackage

// File: rtl/muldiv_timer.sv
// Wait-cycle counter: counts 0..MAX_CYCLES-1 while enabled, flags the last count.
module muldiv_timer #(
  parameter int MAX_CYCLES = 40
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              W    = $clog2(MAX_CYCLES);
  localparam logic [W-1:0]    LAST = W'(MAX_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Holds at the last count; the FSM leaves the wait state on that cycle anyway.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (enable && !expired)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/muldiv_sequencer.sv
// Launches the shared MULT/DIV unit, waits with a watchdog, and drives the
// HI/LO write path or raises a div0/timeout exception pulse.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int MAX_CYCLES = 40
) (
  input  logic clk,
  input  logic reset,
  input  logic op_valid,
  input  logic op_kind,
  input  logic flush,
  output logic op_ready,
  output logic busy,
  output logic mult_start,
  input  logic mult_end,
  output logic div_start,
  input  logic div_end,
  input  logic div_zero,
  output logic hi_sel,
  output logic lo_sel,
  output logic hi_write,
  output logic lo_write,
  output logic done,
  output logic div0_exc,
  output logic timeout_exc
);

  state_e state_q, state_d;
  logic   kind_q,  kind_d;
  logic   cause_q, cause_d;
  logic   tmr_clear, tmr_en, tmr_expired;

  muldiv_timer #(.MAX_CYCLES(MAX_CYCLES)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      kind_q  <= KIND_MULT;
      cause_q <= CAUSE_DIV0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    cause_d   = cause_q;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op_valid && !flush) begin
          kind_d  = op_kind;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        tmr_clear = 1'b1;
        state_d   = (kind_q == KIND_DIV) ? S_WAIT_DIV : S_WAIT_MULT;
      end
      S_WAIT_MULT: begin
        tmr_en = 1'b1;
        if (mult_end) begin
          state_d = S_COMMIT;
        end else if (tmr_expired) begin
          state_d = S_EXC;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_WAIT_DIV: begin
        tmr_en = 1'b1;
        if (div_zero) begin
          state_d = S_EXC;
          cause_d = CAUSE_DIV0;
        end else if (div_end) begin
          state_d = S_COMMIT;
        end else if (tmr_expired) begin
          state_d = S_EXC;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_COMMIT: state_d = S_IDLE;
      S_EXC:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (flush && state_q != S_IDLE)
      state_d = S_IDLE;
  end

  // Pulses are state-decoded; flush masks them in the same cycle so an aborted
  // op never starts a unit, writes HI/LO or raises an exception.
  always_comb begin
    op_ready    = (state_q == S_IDLE);
    busy        = (state_q != S_IDLE);
    hi_sel      = kind_q;
    lo_sel      = kind_q;
    mult_start  = 1'b0;
    div_start   = 1'b0;
    hi_write    = 1'b0;
    lo_write    = 1'b0;
    done        = 1'b0;
    div0_exc    = 1'b0;
    timeout_exc = 1'b0;
    if (!flush) begin
      case (state_q)
        S_LAUNCH: begin
          mult_start = (kind_q == KIND_MULT);
          div_start  = (kind_q == KIND_DIV);
        end
        S_COMMIT: begin
          hi_write = 1'b1;
          lo_write = 1'b1;
          done     = 1'b1;
        end
        S_EXC: begin
          div0_exc    = (cause_q == CAUSE_DIV0);
          timeout_exc = (cause_q == CAUSE_TIMEOUT);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench: stimulus pushes expected completion events, a negedge
// monitor pops and checks kind, cycle, selects and write enables.
module tb_muldiv_sequencer;

  localparam int MAXC = 8;

  logic clk = 1'b0, reset = 1'b0;
  logic op_valid = 1'b0, op_kind = 1'b0, flush = 1'b0;
  logic mult_end = 1'b0, div_end = 1'b0, div_zero = 1'b0;
  logic op_ready, busy, mult_start, div_start, hi_sel, lo_sel;
  logic hi_write, lo_write, done, div0_exc, timeout_exc;

  int checks = 0, failures = 0, cyc = 0;
  bit mon_en = 1'b0;

  typedef enum int {EV_DONE = 0, EV_DIV0 = 1, EV_TO = 2} ev_e;
  typedef struct { ev_e ev; int at; logic sel; } exp_t;
  exp_t sbq[$];

  muldiv_sequencer #(.MAX_CYCLES(MAXC)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_kind(op_kind), .flush(flush),
    .op_ready(op_ready), .busy(busy), .mult_start(mult_start), .mult_end(mult_end),
    .div_start(div_start), .div_end(div_end), .div_zero(div_zero),
    .hi_sel(hi_sel), .lo_sel(lo_sel), .hi_write(hi_write), .lo_write(lo_write),
    .done(done), .div0_exc(div0_exc), .timeout_exc(timeout_exc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic k, output int n);
    op_valid = 1'b1; op_kind = k;
    tick();
    op_valid = 1'b0;
    n = cyc;
  endtask

  task automatic expect_ev(input ev_e ev, input int at, input logic sel);
    exp_t e;
    e.ev = ev; e.at = at; e.sel = sel;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    ev_e  got;
    exp_t e;
    if (mon_en && (done || div0_exc || timeout_exc)) begin
      got = done ? EV_DONE : (div0_exc ? EV_DIV0 : EV_TO);
      if (sbq.size() == 0) begin
        chk("unexpected_event", 32'(got), 32'd99);
      end else begin
        e = sbq.pop_front();
        chk("event_kind",  32'(got), 32'(e.ev));
        chk("event_cycle", 32'(cyc), 32'(e.at));
        chk("hilo_sel",    32'({hi_sel, lo_sel}), 32'({e.sel, e.sel}));
        chk("hilo_write",  32'({hi_write, lo_write}), (got == EV_DONE) ? 32'd3 : 32'd0);
        chk("single_event", 32'(done) + 32'(div0_exc) + 32'(timeout_exc), 32'd1);
      end
    end
  end

  initial begin
    int n;
    // reset state
    tick(); tick();
    reset = 1'b1; #1;
    chk("rst_ready", 32'(op_ready), 32'd1);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_sel",   32'({hi_sel, lo_sel}), 32'd0);
    chk("rst_pulses", 32'({mult_start, div_start, hi_write, lo_write, done, div0_exc, timeout_exc}), 32'd0);
    mon_en = 1'b1;
    tick();

    // MULT, mult_end in third wait cycle
    issue(1'b0, n);
    expect_ev(EV_DONE, n + 4, 1'b0);
    #1;
    chk("t1_mult_start", 32'(mult_start), 32'd1);
    chk("t1_div_start",  32'(div_start), 32'd0);
    chk("t1_ready_launch", 32'(op_ready), 32'd0);
    tick();
    chk("t1_start_one_cycle", 32'(mult_start), 32'd0);
    tick(); tick();
    mult_end = 1'b1;
    tick();
    mult_end = 1'b0; #1;
    chk("t1_ready_commit", 32'(op_ready), 32'd0);
    tick();
    chk("t1_ready_back", 32'(op_ready), 32'd1);

    // DIV with div_end and div_zero together
    issue(1'b1, n);
    expect_ev(EV_DIV0, n + 3, 1'b1);
    #1;
    chk("t2_div_start", 32'(div_start), 32'd1);
    chk("t2_sel_launch", 32'(hi_sel), 32'd1);
    tick();
    chk("t2_sel_wait", 32'(hi_sel), 32'd1);
    tick();
    div_end = 1'b1; div_zero = 1'b1;
    tick();
    div_end = 1'b0; div_zero = 1'b0;
    tick();
    chk("t2_ready", 32'(op_ready), 32'd1);
    chk("t2_sel_idle", 32'({hi_sel, lo_sel}), 32'd3);

    // DIV timeout
    issue(1'b1, n);
    expect_ev(EV_TO, n + 1 + MAXC, 1'b1);
    repeat (MAXC + 1) tick();
    tick();
    chk("t3_ready", 32'(op_ready), 32'd1);

    // DIV ending in the last wait cycle commits
    issue(1'b1, n);
    expect_ev(EV_DONE, n + 1 + MAXC, 1'b1);
    repeat (MAXC) tick();
    div_end = 1'b1;
    tick();
    div_end = 1'b0;
    tick();
    chk("t3b_ready", 32'(op_ready), 32'd1);

    // flush in LAUNCH
    issue(1'b0, n);
    flush = 1'b1; #1;
    chk("t4a_no_start", 32'({mult_start, div_start}), 32'd0);
    tick();
    flush = 1'b0; #1;
    chk("t4a_ready", 32'(op_ready), 32'd1);
    tick(); tick();

    // flush in WAIT_MULT, late mult_end ignored
    issue(1'b0, n);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; #1;
    chk("t4b_ready", 32'(op_ready), 32'd1);
    tick();
    mult_end = 1'b1;
    tick();
    mult_end = 1'b0; #1;
    chk("t4b_idle", 32'(busy), 32'd0);
    tick();

    // op_valid held during a busy DIV, op_kind toggling
    op_valid = 1'b1; op_kind = 1'b1;
    tick();
    n = cyc;
    expect_ev(EV_DONE, n + 3, 1'b1);
    op_kind = 1'b0; #1;
    chk("t5_div_start", 32'(div_start), 32'd1);
    tick();
    mult_end = 1'b1; op_kind = 1'b1; #1;
    chk("t5_sel_hold", 32'(hi_sel), 32'd1);
    chk("t5_not_ready", 32'(op_ready), 32'd0);
    tick();
    mult_end = 1'b0; op_kind = 1'b0; #1;
    chk("t5_stray_ignored", 32'(busy), 32'd1);
    div_end = 1'b1;
    tick();
    div_end = 1'b0; op_kind = 1'b1;
    tick();
    op_kind = 1'b0; #1;
    chk("t5_ready_rise", 32'(op_ready), 32'd1);
    tick();
    op_valid = 1'b0;
    expect_ev(EV_DONE, cyc + 2, 1'b0);
    chk("t5_next_accept", 32'({busy, mult_start, div_start}), 32'd6);
    chk("t5_next_sel", 32'(hi_sel), 32'd0);
    tick();
    mult_end = 1'b1;
    tick();
    mult_end = 1'b0;
    tick();

    // reset pulse in WAIT_DIV
    issue(1'b1, n);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1; #1;
    chk("t6_ready", 32'(op_ready), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_sel", 32'({hi_sel, lo_sel}), 32'd0);
    chk("t6_pulses", 32'({mult_start, div_start, hi_write, lo_write, done, div0_exc, timeout_exc}), 32'd0);
    div_end = 1'b1;
    tick();
    div_end = 1'b0; #1;
    chk("t6_no_write", 32'({busy, hi_write, lo_write}), 32'd0);
    tick(); tick();

    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
